// File: rtl/vld_ram_pkg.sv
// Shared FSM encoding for the valid-qualified RAM burst reader.
// The constants stay plain so older code can compare against them directly.
package vld_ram_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/vld_sync_fifo.sv
// First-word-fall-through synchronous FIFO whose outputs come only from state.
// Reset flushes the pointers, the count and the storage.
module vld_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        // a simultaneous push and pop leaves the occupancy unchanged
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_q];
    assign valid = (cnt_q != '0);
    assign count = cnt_q;

endmodule

// File: rtl/vld_ram_reader.sv
// Burst reader: issues credit-limited RAM reads and streams the words out.
// Credits count reads in flight plus words buffered, so the FIFO cannot overflow.
module vld_ram_reader
    import vld_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_addr_vld,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr_en,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic                  ram_dout_vld,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic                  infl_q, infl_d;
    logic                  infl_last_q, infl_last_d;

    logic [CW-1:0]         fifo_cnt;
    logic [CW-1:0]         credits;
    logic                  fifo_valid;
    logic [DATA_WIDTH:0]   fifo_dout;
    logic                  issue;
    logic                  push;
    logic                  pop;

    assign credits = fifo_cnt + CW'(infl_q);
    assign issue   = (state_q == S_ISSUE) && (credits < CW'(FIFO_DEPTH));
    // responses without a matching request (idle, or after reset) are dropped
    assign push    = ram_dout_vld && infl_q && (state_q != S_IDLE);
    assign pop     = fifo_valid && m_ready;

    assign infl_d      = issue;
    assign infl_last_d = issue && (rem_q == (ADDR_WIDTH+1)'(1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        addr_d  = start_addr;
                        rem_d   = length;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == (ADDR_WIDTH+1)'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && fifo_dout[DATA_WIDTH]) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end

    vld_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({infl_last_q, ram_dout}),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .count (fifo_cnt)
    );

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign ram_addr_vld = issue;
    assign ram_addr     = addr_q;
    assign ram_wr_en    = 1'b0;
    assign ram_din      = '0;
    assign m_valid      = fifo_valid;
    assign m_data       = fifo_dout[DATA_WIDTH-1:0];
    assign m_last       = fifo_valid && fifo_dout[DATA_WIDTH];

endmodule

// File: tb/tb_vld_ram_reader.sv
// Scoreboard bench for vld_ram_reader with a one-cycle-latency RAM model.
// Addresses and words are queued at launch and retired as the DUT emits them.
module tb_vld_ram_reader;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic          ram_addr_vld;
    logic [AW-1:0] ram_addr;
    logic          ram_wr_en;
    logic [DW-1:0] ram_din;
    logic          ram_dout_vld = 1'b0;
    logic [DW-1:0] ram_dout = '0;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    logic          ready_fix;
    logic          rnd_en;
    logic          rnd_bit = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int n_addr = 0;
    int n_acc = 0;
    int n_mv = 0;
    int done_cnt = 0;

    logic [AW-1:0] exp_addr[$];
    logic [DW:0]   exp_word[$];

    always #5 clk = ~clk;

    assign m_ready = rnd_en ? rnd_bit : ready_fix;

    vld_ram_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_addr   (start_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .ram_addr_vld (ram_addr_vld),
        .ram_addr     (ram_addr),
        .ram_wr_en    (ram_wr_en),
        .ram_din      (ram_din),
        .ram_dout_vld (ram_dout_vld),
        .ram_dout     (ram_dout),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last)
    );

    function automatic logic [DW-1:0] ram_word(logic [AW-1:0] a);
        return {4'hC, a, 4'h5, ~a};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        rnd_bit      <= 1'($urandom_range(0, 1));
        ram_dout_vld <= ram_addr_vld;
        ram_dout     <= ram_word(ram_addr);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_addr_vld) begin
                n_addr++;
                if (exp_addr.size() == 0) check("addr_extra", 1, 0);
                else check("ram_addr", 64'(ram_addr), 64'(exp_addr.pop_front()));
            end
            if (m_valid) begin
                n_mv++;
                if (exp_word.size() == 0) begin
                    check("word_extra", 1, 0);
                end else if (m_ready) begin
                    check("m_word", 64'({m_last, m_data}), 64'(exp_word.pop_front()));
                    n_acc++;
                end else begin
                    check("m_hold", 64'({m_last, m_data}), 64'(exp_word[0]));
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic launch(logic [AW-1:0] a, logic [AW:0] n);
        for (int i = 0; i < int'(n); i++) begin
            exp_addr.push_back(a + AW'(i));
            exp_word.push_back({(i == int'(n) - 1), ram_word(a + AW'(i))});
        end
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = a;
        length     = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(int budget, string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 64'(ok), 1);
        check({tag, "_drained"}, 64'(exp_word.size() + exp_addr.size()), 0);
    endtask

    task automatic check_idle_outs(string tag);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_avld"}, 64'(ram_addr_vld), 0);
        check({tag, "_addr"}, 64'(ram_addr), 0);
        check({tag, "_mvalid"}, 64'(m_valid), 0);
        check({tag, "_mlast"}, 64'(m_last), 0);
        check({tag, "_mdata"}, 64'(m_data), 0);
    endtask

    initial begin
        int base;
        int d0;
        logic ok;
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        length     = '0;
        ready_fix  = 1'b1;
        rnd_en     = 1'b0;
        #1;
        check_idle_outs("reset");
        check("reset_wr_en", 64'(ram_wr_en), 0);
        check("reset_din", 64'(ram_din), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // basic burst with exact cycle timing
        base = n_acc;
        launch(12'h010, 13'd4);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("t1_avld_c%0d", k), 64'(ram_addr_vld), 64'(k <= 4));
            check($sformatf("t1_mvalid_c%0d", k), 64'(m_valid), 64'(k >= 3 && k <= 6));
            check($sformatf("t1_done_c%0d", k), 64'(done), 64'(k == 7));
        end
        check("t1_busy_end", 64'(busy), 0);
        check("t1_words", 64'(n_acc - base), 4);

        // address wrap
        launch(12'hFFE, 13'd4);
        wait_done(40, "t2_wrap_done");

        // back-pressure: only FIFO_DEPTH reads may be outstanding
        ready_fix = 1'b0;
        base = n_addr;
        d0   = n_acc;
        launch(12'h200, 13'd16);
        repeat (20) @(negedge clk);
        check("t3_issued", 64'(n_addr - base), FD);
        check("t3_mvalid", 64'(m_valid), 1);
        @(posedge clk);
        #1 ready_fix = 1'b1;
        wait_done(80, "t3_done");
        check("t3_words", 64'(n_acc - d0), 16);

        // zero-length command
        base = n_addr;
        d0   = n_mv;
        launch(12'h300, 13'd0);
        @(negedge clk);
        check("t4_done_c1", 64'(done), 1);
        check("t4_busy_c1", 64'(busy), 1);
        @(negedge clk);
        check("t4_busy_c2", 64'(busy), 0);
        check("t4_done_c2", 64'(done), 0);
        check("t4_no_req", 64'(n_addr - base), 0);
        check("t4_no_mv", 64'(n_mv - d0), 0);

        // reset in the middle of a burst
        base = n_acc;
        launch(12'h400, 13'd8);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            if (n_acc - base >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_reach3", 64'(ok), 1);
        #2 rst = 1'b1;
        #1;
        check_idle_outs("t5_rst");
        exp_addr.delete();
        exp_word.delete();
        #1 rst = 1'b0;
        d0 = done_cnt;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_late_drop", 64'(m_valid), 0);
            check("t5_busy", 64'(busy), 0);
        end
        check("t5_no_done", 64'(done_cnt - d0), 0);
        launch(12'h500, 13'd2);
        wait_done(30, "t5_fresh_done");

        // start while busy has no effect
        launch(12'h600, 13'd6);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = 12'h700;
        length     = 13'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(40, "t6_done");

        // single-word burst
        launch(12'hABC, 13'd1);
        wait_done(20, "t7_len1_done");

        // random sink stalls
        rnd_en = 1'b1;
        for (int b = 0; b < 4; b++) begin
            launch(AW'($urandom_range(0, 4095)), (AW+1)'($urandom_range(1, 12)));
            wait_done(200, $sformatf("t8_rand%0d_done", b));
        end
        rnd_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule
